// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage.
// Accepts one load/store at a time through a valid/ready handshake, waits a
// fixed number of wait states, then completes the access against an internal
// word-addressed RAM and pulses a one-cycle response. While an access is
// outstanding it holds MEM_STALL so the pipeline stays frozen.
module data_memory_responder #(
  parameter int WORD_LEN    = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_LEN    = 8,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ_VALID,
  input  logic                REQ_WRITE,
  input  logic [WORD_LEN-1:0] REQ_ADDR,
  input  logic [WORD_LEN-1:0] REQ_WDATA,
  output logic                REQ_READY,
  output logic                RESP_VALID,
  output logic [WORD_LEN-1:0] RESP_RDATA,
  output logic                RESP_ERR,
  output logic                MEM_STALL
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [WORD_LEN-1:0] BASE      = WORD_LEN'(BASE_ADDR);
  localparam logic [WORD_LEN-1:0] SPAN      = WORD_LEN'(4 * DEPTH);
  // Only used when WAIT_STATES > 0; the counter runs WAIT_STATES-1 .. 0.
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_wait_cnt;
  logic [3:0]          w_wait_cnt_next;
  logic                w_enter_resp;

  logic                r_req_write;
  logic [WORD_LEN-1:0] r_req_addr;
  logic [WORD_LEN-1:0] r_req_wdata;

  logic                w_cur_write;
  logic [WORD_LEN-1:0] w_cur_addr;
  logic [WORD_LEN-1:0] w_cur_wdata;
  logic [WORD_LEN-1:0] w_offset;
  logic [ADDR_LEN-1:0] w_index;
  logic                w_err;
  logic                w_mem_we;

  logic [WORD_LEN-1:0] r_mem [DEPTH];
  logic [WORD_LEN-1:0] r_resp_rdata;
  logic                r_resp_err;

  // State register and wait counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Next-state, counter and handshake/stall outputs.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_enter_resp    = 1'b0;
    REQ_READY       = 1'b0;
    RESP_VALID      = 1'b0;
    MEM_STALL       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        REQ_READY = 1'b1;
        MEM_STALL = REQ_VALID;
        if (REQ_VALID) begin
          if (WAIT_STATES == 0) begin
            w_state_next = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next    = S_WAIT;
            w_wait_cnt_next = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        MEM_STALL = 1'b1;
        if (r_wait_cnt == 4'd0) begin
          w_state_next = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 4'd1;
        end
      end
      S_RESP: begin
        RESP_VALID   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the request at acceptance; later input changes are ignored.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else if (r_state == S_IDLE && REQ_VALID) begin
      r_req_write <= REQ_WRITE;
      r_req_addr  <= REQ_ADDR;
      r_req_wdata <= REQ_WDATA;
    end
  end

  // With zero wait states the access completes on the acceptance edge, so
  // the live request is used in IDLE and the captured copy everywhere else.
  always_comb begin
    w_cur_write = (r_state == S_IDLE) ? REQ_WRITE : r_req_write;
    w_cur_addr  = (r_state == S_IDLE) ? REQ_ADDR  : r_req_addr;
    w_cur_wdata = (r_state == S_IDLE) ? REQ_WDATA : r_req_wdata;
  end

  // Address decode: offset wraps modulo 2^WORD_LEN, so an address below the
  // base becomes a huge offset and falls into the out-of-range check.
  always_comb begin
    w_offset = w_cur_addr - BASE;
    w_index  = w_offset[ADDR_LEN+1:2];
    w_err    = (w_offset[1:0] != 2'b00) || (w_offset >= SPAN);
  end

  // A store lands only on the edge entering RESP, never on error, and never
  // while reset is held (a pending store is dropped by reset).
  assign w_mem_we = w_enter_resp && w_cur_write && !w_err && RESET;

  // RAM write port.
  // NOTE: the RAM array has no reset so it maps onto plain memory; only the
  // control and response registers are reset.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_index] <= w_cur_wdata;
    end
  end

  // Response data/error registered on the edge entering RESP; data holds
  // until the next response, the error flag lives only for the RESP cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_resp_err   <= w_err;
      r_resp_rdata <= (w_cur_write || w_err) ? '0 : r_mem[w_index];
    end else begin
      r_resp_err   <= 1'b0;
    end
  end

  assign RESP_RDATA = r_resp_rdata;
  assign RESP_ERR   = r_resp_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 and 0 wait states),
// a table of load/store vectors, plus hand sequences for reset mid-access
// and a request held valid across two back-to-back accesses.
module tb_data_memory_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    int          sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        mem_stall  [2];

  int    ws_of [2] = '{2, 0};
  int    stall_cnt [2] = '{0, 0};
  int    cyc = 0;
  int    n_vec = 0;
  int    n_fail = 0;
  resp_t exp_q0 [$];
  resp_t exp_q1 [$];
  resp_t got_q0 [$];
  resp_t got_q1 [$];
  vec_t  vecs [10];

  data_memory_responder #(.WAIT_STATES(2)) u_dut_ws2 (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(req_valid[0]), .REQ_WRITE(req_write[0]),
    .REQ_ADDR(req_addr[0]), .REQ_WDATA(req_wdata[0]),
    .REQ_READY(req_ready[0]), .RESP_VALID(resp_valid[0]),
    .RESP_RDATA(resp_rdata[0]), .RESP_ERR(resp_err[0]),
    .MEM_STALL(mem_stall[0])
  );

  data_memory_responder #(.WAIT_STATES(0)) u_dut_ws0 (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(req_valid[1]), .REQ_WRITE(req_write[1]),
    .REQ_ADDR(req_addr[1]), .REQ_WDATA(req_wdata[1]),
    .REQ_READY(req_ready[1]), .RESP_VALID(resp_valid[1]),
    .RESP_RDATA(resp_rdata[1]), .RESP_ERR(resp_err[1]),
    .MEM_STALL(mem_stall[1])
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: count stall cycles and record every response strobe.
  always @(negedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (mem_stall[s] === 1'b1) stall_cnt[s] <= stall_cnt[s] + 1;
      if (resp_valid[s] === 1'b1) begin
        if (s == 0) got_q0.push_back('{resp_rdata[s], resp_err[s], cyc});
        else        got_q1.push_back('{resp_rdata[s], resp_err[s], cyc});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[sel] = v;
    req_write[sel] = wr;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
  endtask

  // Expected response: acceptance at the next edge (cyc+1), RESP is the
  // (ws+1)-th cycle after it, i.e. the cycle that starts at edge cyc+1+ws.
  task automatic push_exp(input int sel, input logic [31:0] rdata, input logic err);
    resp_t e;
    e = '{rdata, err, cyc + 1 + ws_of[sel]};
    if (sel == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
  endtask

  function automatic int got_size(input int sel);
    return (sel == 0) ? got_q0.size() : got_q1.size();
  endfunction

  // Wait (bounded) for the next response and compare it with the scoreboard.
  task automatic wait_resp(input int sel, input string name);
    resp_t g;
    resp_t e;
    for (int i = 0; i < 40 && got_size(sel) == 0; i++) begin
      @(negedge CLK); #1;
    end
    if (got_size(sel) == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: got no response, want one within 40 cycles", name);
      if (sel == 0) void'(exp_q0.pop_front());
      else          void'(exp_q1.pop_front());
    end else begin
      if (sel == 0) begin g = got_q0.pop_front(); e = exp_q0.pop_front(); end
      else          begin g = got_q1.pop_front(); e = exp_q1.pop_front(); end
      check({name, "_rdata"}, g.rdata, e.rdata);
      check({name, "_err"},   32'(g.err), 32'(e.err));
      check({name, "_cycle"}, 32'(g.cyc), 32'(e.cyc));
    end
  endtask

  // One complete access with ready, latency and stall-length checks.
  task automatic do_access(input vec_t v, input string name);
    int s0;
    @(posedge CLK); #1;
    drive(v.sel, 1'b1, v.wr, v.addr, v.wdata);
    push_exp(v.sel, v.rdata, v.err);
    s0 = stall_cnt[v.sel];
    @(negedge CLK); #1;
    check({name, "_ready"}, 32'(req_ready[v.sel]), 32'd1);
    @(posedge CLK); #1;
    drive(v.sel, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_resp(v.sel, name);
    check({name, "_stall_len"}, 32'(stall_cnt[v.sel] - s0), 32'(ws_of[v.sel] + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int s = 0; s < 2; s++) drive(s, 1'b0, 1'b0, 32'd0, 32'd0);

    //           sel wr    addr    wdata          rdata          err
    vecs[0] = '{0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{0, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1, 1'b1, 32'd1024, 32'h12345678, 32'h0,        1'b0};
    vecs[3] = '{1, 1'b0, 32'd1024, 32'h0,        32'h12345678, 1'b0};
    vecs[4] = '{1, 1'b1, 32'd1026, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[5] = '{1, 1'b0, 32'd1024, 32'h0,        32'h12345678, 1'b0};
    vecs[6] = '{0, 1'b0, 32'd2048, 32'h0,        32'h0,        1'b1};
    vecs[7] = '{0, 1'b0, 32'd1020, 32'h0,        32'h0,        1'b1};
    vecs[8] = '{1, 1'b1, 32'd2044, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[9] = '{1, 1'b0, 32'd2044, 32'h0,        32'hCAFEF00D, 1'b0};

    // Reset state of both instances.
    repeat (3) @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst%0d_ready", s), 32'(req_ready[s]),  32'd1);
      check($sformatf("rst%0d_valid", s), 32'(resp_valid[s]), 32'd0);
      check($sformatf("rst%0d_rdata", s), resp_rdata[s],      32'd0);
      check($sformatf("rst%0d_err", s),   32'(resp_err[s]),   32'd0);
      check($sformatf("rst%0d_stall", s), 32'(mem_stall[s]),  32'd0);
    end
    RESET = 1'b1;

    // Table-driven loads/stores, including misaligned and out-of-range.
    for (int i = 0; i < 10; i++) do_access(vecs[i], $sformatf("vec%0d", i));

    // Reset during WAIT of a store: store discarded, no response.
    v = '{0, 1'b1, 32'd1032, 32'h0BADF00D, 32'h0, 1'b0};
    do_access(v, "t5_prestore");
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b1, 32'd1032, 32'hAAAA5555);
    @(posedge CLK); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge CLK); #1;
    check("t5_in_wait_ready", 32'(req_ready[0]), 32'd0);
    RESET = 1'b0;
    #1;
    check("t5_rst_ready", 32'(req_ready[0]),  32'd1);
    check("t5_rst_valid", 32'(resp_valid[0]), 32'd0);
    check("t5_rst_rdata", resp_rdata[0],      32'd0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK); #1;
    check("t5_release_ready", 32'(req_ready[0]), 32'd1);
    repeat (4) @(negedge CLK);
    #1;
    check("t5_no_resp", 32'(got_q0.size() + got_q1.size()), 32'd0);
    v = '{0, 1'b0, 32'd1032, 32'h0, 32'h0BADF00D, 1'b0};
    do_access(v, "t5_load");

    // REQ_VALID held high across two requests; inputs change during WAIT.
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b1, 32'd1036, 32'h11111111);
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 32'h0, 1'b0);
      @(negedge CLK); #1;
      check($sformatf("t6_r%0d_idle_ready", r), 32'(req_ready[0]), 32'd1);
      check($sformatf("t6_r%0d_idle_stall", r), 32'(mem_stall[0]), 32'd1);
      @(posedge CLK); #1;
      if (r == 0) drive(0, 1'b1, 1'b1, 32'd1040, 32'h22222222);
      else        drive(0, 1'b1, 1'b1, 32'd1036, 32'h99999999);
      for (int w = 0; w < 2; w++) begin
        @(negedge CLK); #1;
        check($sformatf("t6_r%0d_wait%0d_ready", r, w), 32'(req_ready[0]), 32'd0);
        check($sformatf("t6_r%0d_wait%0d_stall", r, w), 32'(mem_stall[0]), 32'd1);
      end
      @(posedge CLK); #1;
      if (r == 1) drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge CLK); #1;
      check($sformatf("t6_r%0d_resp_ready", r), 32'(req_ready[0]), 32'd0);
      check($sformatf("t6_r%0d_resp_stall", r), 32'(mem_stall[0]), 32'd0);
      wait_resp(0, $sformatf("t6_r%0d", r));
      @(posedge CLK); #1;
    end
    repeat (4) @(negedge CLK);
    #1;
    check("t6_resp_count", 32'(got_q0.size()), 32'd0);
    v = '{0, 1'b0, 32'd1036, 32'h0, 32'h11111111, 1'b0};
    do_access(v, "t6_load_a");
    v = '{0, 1'b0, 32'd1040, 32'h0, 32'h22222222, 1'b0};
    do_access(v, "t6_load_b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
